// File: rtl/morse_pkg.sv
// Shared Morse definitions used by the keyer and the receive-side decoder.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GAP_ELEM,
    GAP_CHAR,
    GAP_WORD
  } morse_state_t;

  localparam int DOT_UNITS      = 1;
  localparam int ELEM_GAP_UNITS = 1;
  localparam int MAX_ELEMS      = 5;
  localparam int UNIT_CNT_W     = 8;

  // char_len encoding: 0 = word space, 1..5 = element count
  localparam logic [2:0] LEN_WORD_SPACE = 3'd0;
  localparam logic [2:0] LEN_MAX        = 3'(MAX_ELEMS);

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Cycle prescaler and unit counter; clr restarts both so each interval is exact.
module morse_unit_timer #(
  parameter int UNIT_CLKS  = 50000000,
  parameter int UNIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  unit_tick,
  output logic [UNIT_CNT_W-1:0] unit_cnt
);

  localparam int CYC_W = $clog2(UNIT_CLKS);

  logic [CYC_W-1:0]      cyc_reg;
  logic [UNIT_CNT_W-1:0] unit_reg;

  assign unit_tick = (cyc_reg == CYC_W'(UNIT_CLKS - 1));
  assign unit_cnt  = unit_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_reg  <= '0;
      unit_reg <= '0;
    end else if (clr) begin
      cyc_reg  <= '0;
      unit_reg <= '0;
    end else if (unit_tick) begin
      cyc_reg  <= '0;
      unit_reg <= unit_reg + 1'b1;
    end else begin
      cyc_reg  <= cyc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/morse_transmitter.sv
// Morse keyer: accepts one character per handshake and keys it with unit timing.
// Define MORSE_SIDETONE_EN to add the tone output and its divider.
module morse_transmitter
  import morse_pkg::*;
#(
  parameter int UNIT_CLKS      = 50000000,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
`ifdef MORSE_SIDETONE_EN
  ,
  parameter int TONE_HALF_CLKS = 25000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [2:0] char_len,
  input  logic [4:0] char_bits,
  output logic       key,
  output logic       dot,
  output logic       dash,
  output logic       interchar,
  output logic       interword,
  output logic       busy
`ifdef MORSE_SIDETONE_EN
  ,
  output logic       tone
`endif
);

  morse_state_t    state_reg;
  logic [4:0]      bits_reg;
  logic [2:0]      len_reg;
  logic [2:0]      idx_reg;
  logic            key_reg, dot_reg, dash_reg;
  logic            interchar_reg, interword_reg, busy_reg;

  logic                  unit_tick;
  logic [UNIT_CNT_W-1:0] unit_cnt;
  logic [UNIT_CNT_W-1:0] target_units;
  logic [UNIT_CNT_W-1:0] elem_units [MAX_ELEMS];
  logic                  interval_done;
  logic                  timer_clr;
  logic                  accept;
  logic                  last_elem;
  logic [2:0]            acc_len;
  logic [2:0]            next_idx;

  assign char_ready = (state_reg == IDLE) & reset;
  assign accept     = char_valid & char_ready;
  assign acc_len    = clamp_len(char_len);
  assign next_idx   = idx_reg + 3'd1;
  assign last_elem  = (idx_reg == len_reg - 3'd1);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ELEMS; gi++) begin : g_elem_units
      assign elem_units[gi] = bits_reg[gi] ? UNIT_CNT_W'(DASH_UNITS) : UNIT_CNT_W'(DOT_UNITS);
    end
  endgenerate

  always_comb begin
    target_units = UNIT_CNT_W'(DOT_UNITS);
    case (state_reg)
      MARK:     target_units = elem_units[idx_reg];
      GAP_ELEM: target_units = UNIT_CNT_W'(ELEM_GAP_UNITS);
      GAP_CHAR: target_units = UNIT_CNT_W'(CHAR_GAP_UNITS);
      GAP_WORD: target_units = UNIT_CNT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
      default:  target_units = UNIT_CNT_W'(DOT_UNITS);
    endcase
  end

  // Timer is held clear in IDLE and cleared on every interval end, i.e. on each state entry
  assign interval_done = (state_reg != IDLE) && unit_tick && (unit_cnt == target_units - 1'b1);
  assign timer_clr     = (state_reg == IDLE) || interval_done;

  morse_unit_timer #(
    .UNIT_CLKS  (UNIT_CLKS),
    .UNIT_CNT_W (UNIT_CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (timer_clr),
    .unit_tick (unit_tick),
    .unit_cnt  (unit_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bits_reg      <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      key_reg       <= 1'b0;
      dot_reg       <= 1'b0;
      dash_reg      <= 1'b0;
      interchar_reg <= 1'b0;
      interword_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bits_reg <= char_bits;
            len_reg  <= acc_len;
            idx_reg  <= '0;
            busy_reg <= 1'b1;
            if (acc_len == LEN_WORD_SPACE) begin
              state_reg     <= GAP_WORD;
              interword_reg <= 1'b1;
            end else begin
              state_reg <= MARK;
              key_reg   <= 1'b1;
              dot_reg   <= ~char_bits[0];
              dash_reg  <= char_bits[0];
            end
          end
        end
        MARK: begin
          if (interval_done) begin
            key_reg  <= 1'b0;
            dot_reg  <= 1'b0;
            dash_reg <= 1'b0;
            if (last_elem) begin
              state_reg     <= GAP_CHAR;
              interchar_reg <= 1'b1;
            end else begin
              state_reg <= GAP_ELEM;
            end
          end
        end
        GAP_ELEM: begin
          if (interval_done) begin
            state_reg <= MARK;
            idx_reg   <= next_idx;
            key_reg   <= 1'b1;
            dot_reg   <= ~bits_reg[next_idx];
            dash_reg  <= bits_reg[next_idx];
          end
        end
        GAP_CHAR: begin
          if (interval_done) begin
            state_reg     <= IDLE;
            interchar_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        GAP_WORD: begin
          if (interval_done) begin
            state_reg     <= IDLE;
            interword_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          key_reg       <= 1'b0;
          dot_reg       <= 1'b0;
          dash_reg      <= 1'b0;
          interchar_reg <= 1'b0;
          interword_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign key       = key_reg;
  assign dot       = dot_reg;
  assign dash      = dash_reg;
  assign interchar = interchar_reg;
  assign interword = interword_reg;
  assign busy      = busy_reg;

`ifdef MORSE_SIDETONE_EN
  localparam int TONE_W = $clog2(TONE_HALF_CLKS + 1);

  logic [TONE_W-1:0] tone_div_reg;
  logic              tone_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tone_div_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (!key_reg) begin
      tone_div_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (tone_div_reg == TONE_W'(TONE_HALF_CLKS - 1)) begin
      tone_div_reg <= '0;
      tone_reg     <= ~tone_reg;
    end else begin
      tone_div_reg <= tone_div_reg + 1'b1;
    end
  end

  // Gate with key so the tone is silent from the very first gap cycle
  assign tone = tone_reg & key_reg;
`endif

endmodule

// File: tb/tb_morse_transmitter.sv
// Self-checking bench for morse_transmitter with UNIT_CLKS=4.
module tb_morse_transmitter;

  localparam int U      = 4;
  localparam int DASH_U = 3;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 7;
  localparam int THALF  = 2;

  // {key, dot, dash, interchar, interword, busy, char_ready}
  localparam logic [6:0] C_DOT  = 7'b1100010;
  localparam logic [6:0] C_DASH = 7'b1010010;
  localparam logic [6:0] C_EGAP = 7'b0000010;
  localparam logic [6:0] C_CGAP = 7'b0001010;
  localparam logic [6:0] C_WGAP = 7'b0000110;
  localparam logic [6:0] C_IDLE = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic [2:0] char_len = '0;
  logic [4:0] char_bits = '0;
  logic       char_ready, key, dot, dash, interchar, interword, busy;
`ifdef MORSE_SIDETONE_EN
  logic       tone;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];
  logic       exp_tone_q[$];

  typedef struct {
    logic [2:0] len;
    logic [4:0] bits;
    int         on_cyc;
    int         busy_cyc;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  morse_transmitter #(
    .UNIT_CLKS      (U),
    .DASH_UNITS     (DASH_U),
    .CHAR_GAP_UNITS (CGAP_U),
    .WORD_GAP_UNITS (WGAP_U)
`ifdef MORSE_SIDETONE_EN
    ,
    .TONE_HALF_CLKS (THALF)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_len   (char_len),
    .char_bits  (char_bits),
    .key        (key),
    .dot        (dot),
    .dash       (dash),
    .interchar  (interchar),
    .interword  (interword),
    .busy       (busy)
`ifdef MORSE_SIDETONE_EN
    ,
    .tone       (tone)
`endif
  );

  function automatic logic [6:0] obs();
    return {key, dot, dash, interchar, interword, busy, char_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_n(input logic [6:0] code, input int cycles, input bit is_mark);
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(code);
      exp_tone_q.push_back(is_mark ? (((i / THALF) % 2) == 1) : 1'b0);
    end
  endtask

  // Expected per-cycle trace from the unit rules, starting the cycle after accept
  task automatic build_expected(input logic [2:0] len, input logic [4:0] bits);
    int n;
    exp_q.delete();
    exp_tone_q.delete();
    n = (len > 3'd5) ? 5 : int'(len);
    if (n == 0) begin
      push_n(C_WGAP, (WGAP_U - CGAP_U) * U, 1'b0);
    end else begin
      for (int e = 0; e < n; e++) begin
        if (bits[e]) push_n(C_DASH, DASH_U * U, 1'b1);
        else         push_n(C_DOT, U, 1'b1);
        if (e < n - 1) push_n(C_EGAP, U, 1'b0);
      end
      push_n(C_CGAP, CGAP_U * U, 1'b0);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (char_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(char_ready), 32'd1);
  endtask

  // Entered at the first negedge after accept; leaves at the idle negedge
  task automatic play(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      check(name, 32'(obs()), 32'(exp_q[i]));
`ifdef MORSE_SIDETONE_EN
      check({name, "_tone"}, 32'(tone), 32'(exp_tone_q[i]));
`endif
      @(negedge clk);
    end
    check({name, "_idle"}, 32'(obs()), 32'(C_IDLE));
  endtask

  task automatic send_check(input string name, input logic [2:0] len, input logic [4:0] bits);
    build_expected(len, bits);
    wait_ready();
    char_valid = 1'b1;
    char_len   = len;
    char_bits  = bits;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    char_bits  = 5'($urandom);
    char_len   = 3'($urandom);
    play(name);
    $display("tx %s len=%0d bits=%b cycles=%0d", name, len, bits, exp_q.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 3'd1, bits: 5'b00000, on_cyc: 4,  busy_cyc: 16};
    vecs[1] = '{len: 3'd2, bits: 5'b00010, on_cyc: 16, busy_cyc: 32};
    vecs[2] = '{len: 3'd7, bits: 5'b11111, on_cyc: 60, busy_cyc: 88};
    vecs[3] = '{len: 3'd0, bits: 5'b10101, on_cyc: 0,  busy_cyc: 16};
    vecs[4] = '{len: 3'd6, bits: 5'b01010, on_cyc: 36, busy_cyc: 64};
    vecs[5] = '{len: 3'd3, bits: 5'b11000, on_cyc: 12, busy_cyc: 32};

    repeat (3) @(negedge clk);
    check("reset_state", 32'(obs()), 32'd0);
    reset = 1'b1;
    #1;
    check("reset_release", 32'(obs()), 32'(C_IDLE));
    @(negedge clk);

    send_check("E", 3'd1, 5'b00000);
    send_check("A", 3'd2, 5'b00010);
    send_check("E_then", 3'd1, 5'b00000);
    send_check("word_space", 3'd0, 5'b00000);

    // Table: key-on and busy durations measured per character
    for (int v = 0; v < 6; v++) begin
      int on_cnt, busy_cnt, guard;
      wait_ready();
      char_valid = 1'b1;
      char_len   = vecs[v].len;
      char_bits  = vecs[v].bits;
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
      on_cnt = 0;
      busy_cnt = 0;
      guard = 0;
      while (busy === 1'b1 && guard < 300) begin
        if (key === 1'b1) on_cnt++;
        busy_cnt++;
        guard++;
        @(negedge clk);
      end
      check($sformatf("vec%0d_on", v), 32'(on_cnt), 32'(vecs[v].on_cyc));
      check($sformatf("vec%0d_busy", v), 32'(busy_cnt), 32'(vecs[v].busy_cyc));
      check($sformatf("vec%0d_ready", v), 32'(char_ready), 32'd1);
      $display("tx vec%0d len=%0d bits=%b on=%0d busy=%0d", v, vecs[v].len, vecs[v].bits, on_cnt, busy_cnt);
    end

    // char_valid held and inputs changed while busy: latched 'A' must play out, then 'T'
    build_expected(3'd2, 5'b00010);
    wait_ready();
    char_valid = 1'b1;
    char_len   = 3'd2;
    char_bits  = 5'b00010;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      check("hold_A", 32'(obs()), 32'(exp_q[i]));
      if (i == 6) begin
        char_bits = 5'b11111;
        char_len  = 3'd1;
      end
      @(negedge clk);
    end
    check("hold_A_idle", 32'(obs()), 32'(C_IDLE));
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    build_expected(3'd1, 5'b11111);
    play("hold_T");
    $display("tx hold sequence A then T");

    // Asynchronous reset in the middle of a dash
    wait_ready();
    char_valid = 1'b1;
    char_len   = 3'd1;
    char_bits  = 5'b00001;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_dash", 32'({key, dash, busy}), 32'b111);
    reset = 1'b0;
    #1;
    check("rst_async", 32'({key, dash, busy, char_ready}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_after", 32'(obs()), 32'(C_IDLE));
    send_check("E_after_rst", 3'd1, 5'b00000);

    // Randomized characters against the reference trace
    for (int r = 0; r < 16; r++) begin
      logic [2:0] rl;
      logic [4:0] rb;
      rl = 3'($urandom_range(0, 7));
      rb = 5'($urandom);
      send_check($sformatf("rand%0d", r), rl, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
